// File: rtl/dcache_wb_pkg.sv
// Shared types for the write-back L1 data cache: address layout, frame record and controller states.
// The HCNT state exists only when DCACHE_HITCOUNT_EN is defined.
package dcache_wb_pkg;

    localparam int SETS  = 8;
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - IDX_W - 3;

    typedef logic [31:0] word_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] idx;
        logic             blkoff;
        logic [1:0]       bytoff;
    } dcachef_t;

    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [TAG_W-1:0] tag;
        word_t [1:0]      word;
    } dcache_frame_t;

    typedef enum logic [3:0] {
        IDLE, WB0, WB1, LD0, LD1, FLUSH, FWB0, FWB1,
`ifdef DCACHE_HITCOUNT_EN
        HCNT,
`endif
        DONE
    } dcache_state_t;

    // Byte address of one word of a block.
    function automatic word_t blk_addr(logic [TAG_W-1:0] tag, logic [IDX_W-1:0] idx, logic blk);
        return {tag, idx, blk, 2'b00};
    endfunction

endpackage

// File: rtl/dcache_wb_if.sv
// Pipeline-side and memory-controller-side signals of the data cache.
// slave = the cache's view, master = the environment's view.
interface dcache_wb_if;
    import dcache_wb_pkg::*;

    logic  halt;
    logic  dmemREN;
    logic  dmemWEN;
    word_t dmemaddr;
    word_t dmemstore;
    logic  dhit;
    word_t dmemload;
    logic  flushed;
    logic  dREN;
    logic  dWEN;
    word_t daddr;
    word_t dstore;
    logic  dwait;
    word_t dload;

    modport slave (
        input  halt, dmemREN, dmemWEN, dmemaddr, dmemstore, dwait, dload,
        output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
    );

    modport master (
        output halt, dmemREN, dmemWEN, dmemaddr, dmemstore, dwait, dload,
        input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
    );

endinterface

// File: rtl/dcache_wb_frame_array.sv
// Frame storage for dcache_wb: one asynchronous read port, one write port with
// per-word enables and a separate tag/valid/dirty update.
module dcache_wb_frame_array
    import dcache_wb_pkg::*;
(
    input  logic             CLK,
    input  logic             nRST,
    input  logic [IDX_W-1:0] ridx,
    output dcache_frame_t    rframe,
    input  logic [IDX_W-1:0] widx,
    input  logic [1:0]       wen,
    input  word_t            wdata,
    input  logic             mwen,
    input  logic             wvalid,
    input  logic             wdirty,
    input  logic [TAG_W-1:0] wtag
);

    dcache_frame_t frames [SETS];

    assign rframe = frames[ridx];

    // NOTE: the array is cleared by reset so valid bits start at 0; it is small enough to live in flops.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < SETS; i++) frames[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop update ordered against the same clock edge.
            if (wen[0]) frames[widx].word[0] <= wdata;
            if (wen[1]) frames[widx].word[1] <= wdata;
            if (mwen) begin
                frames[widx].valid <= wvalid;
                frames[widx].dirty <= wdirty;
                frames[widx].tag   <= wtag;
            end
        end
    end

endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate L1 data cache with flush-on-halt.
// Define DCACHE_HITCOUNT_EN to append a hit-minus-miss count write after the flush.
module dcache_wb
    import dcache_wb_pkg::*;
`ifdef DCACHE_HITCOUNT_EN
#(
    parameter word_t HITADDR = 32'h3100
)
`endif
(
    input logic        CLK,
    input logic        nRST,
    dcache_wb_if.slave bus
);

    dcache_state_t    state;
    logic [IDX_W-1:0] fcnt;
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;

    logic [TAG_W-1:0] cpu_tag;
    logic [IDX_W-1:0] cpu_idx;
    logic             cpu_blk;
    logic             req, hit, victim_dirty;

    dcache_frame_t    fr;
    logic [IDX_W-1:0] ridx, widx;
    logic [1:0]       wen;
    word_t            wdata;
    logic             mwen, wvalid, wdirty;
    logic [TAG_W-1:0] wtag;

    assign {cpu_tag, cpu_idx, cpu_blk} = bus.dmemaddr[31:2];
    assign req          = bus.dmemREN | bus.dmemWEN;
    assign hit          = (state == IDLE) & ~bus.halt & req & fr.valid & (fr.tag == cpu_tag);
    assign victim_dirty = fr.valid & fr.dirty;
    assign bus.dhit     = hit;
    assign bus.dmemload = hit ? fr.word[cpu_blk] : '0;

    dcache_wb_frame_array u_frames (
        .CLK(CLK), .nRST(nRST),
        .ridx(ridx), .rframe(fr),
        .widx(widx), .wen(wen), .wdata(wdata),
        .mwen(mwen), .wvalid(wvalid), .wdirty(wdirty), .wtag(wtag)
    );

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        ridx = cpu_idx;
        case (state)
            WB0, WB1, LD0, LD1: ridx = req_idx;
            FLUSH, FWB0, FWB1:  ridx = fcnt;
            default: ;
        endcase
    end

    always_comb begin
        widx   = req_idx;
        wen    = 2'b00;
        wdata  = bus.dload;
        mwen   = 1'b0;
        wvalid = fr.valid;
        wdirty = fr.dirty;
        wtag   = fr.tag;
        case (state)
            IDLE: if (hit && bus.dmemWEN) begin
                widx   = cpu_idx;
                wen    = cpu_blk ? 2'b10 : 2'b01;
                wdata  = bus.dmemstore;
                mwen   = 1'b1;
                wvalid = 1'b1;
                wdirty = 1'b1;
                wtag   = cpu_tag;
            end
            LD0: if (!bus.dwait) wen = 2'b01;
            LD1: if (!bus.dwait) begin
                wen    = 2'b10;
                mwen   = 1'b1;
                wvalid = 1'b1;
                wdirty = 1'b0;
                wtag   = req_tag;
            end
            FWB1: if (!bus.dwait) begin
                widx   = fcnt;
                mwen   = 1'b1;
                wdirty = 1'b0;
            end
            default: ;
        endcase
    end

`ifdef DCACHE_HITCOUNT_EN
    word_t hitcount;

    // Every miss enters LD0 exactly once, either straight from IDLE or after a write-back.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            hitcount <= '0;
        else if (hit)
            hitcount <= hitcount + 32'd1;
        else if ((state == IDLE && !bus.halt && req && !victim_dirty) ||
                 (state == WB1 && !bus.dwait))
            hitcount <= hitcount - 32'd1;
    end
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= IDLE;
            fcnt        <= '0;
            req_tag     <= '0;
            req_idx     <= '0;
            bus.dREN    <= 1'b0;
            bus.dWEN    <= 1'b0;
            bus.daddr   <= '0;
            bus.dstore  <= '0;
            bus.flushed <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.halt) begin
                        state <= FLUSH;
                        fcnt  <= '0;
                    end else if (req && !hit) begin
                        req_tag <= cpu_tag;
                        req_idx <= cpu_idx;
                        if (victim_dirty) begin
                            state      <= WB0;
                            bus.dWEN   <= 1'b1;
                            bus.daddr  <= blk_addr(fr.tag, cpu_idx, 1'b0);
                            bus.dstore <= fr.word[0];
                        end else begin
                            state     <= LD0;
                            bus.dREN  <= 1'b1;
                            bus.daddr <= blk_addr(cpu_tag, cpu_idx, 1'b0);
                        end
                    end
                end
                WB0: if (!bus.dwait) begin
                    state      <= WB1;
                    bus.daddr  <= blk_addr(fr.tag, req_idx, 1'b1);
                    bus.dstore <= fr.word[1];
                end
                WB1: if (!bus.dwait) begin
                    state     <= LD0;
                    bus.dWEN  <= 1'b0;
                    bus.dREN  <= 1'b1;
                    bus.daddr <= blk_addr(req_tag, req_idx, 1'b0);
                end
                LD0: if (!bus.dwait) begin
                    state     <= LD1;
                    bus.daddr <= blk_addr(req_tag, req_idx, 1'b1);
                end
                LD1: if (!bus.dwait) begin
                    state    <= IDLE;
                    bus.dREN <= 1'b0;
                end
                FLUSH: begin
                    if (victim_dirty) begin
                        state      <= FWB0;
                        bus.dWEN   <= 1'b1;
                        bus.daddr  <= blk_addr(fr.tag, fcnt, 1'b0);
                        bus.dstore <= fr.word[0];
                    end else if (fcnt == IDX_W'(SETS - 1)) begin
`ifdef DCACHE_HITCOUNT_EN
                        state      <= HCNT;
                        bus.dWEN   <= 1'b1;
                        bus.daddr  <= HITADDR;
                        bus.dstore <= hitcount;
`else
                        state       <= DONE;
                        bus.flushed <= 1'b1;
`endif
                    end else begin
                        fcnt <= fcnt + 1'b1;
                    end
                end
                FWB0: if (!bus.dwait) begin
                    state      <= FWB1;
                    bus.daddr  <= blk_addr(fr.tag, fcnt, 1'b1);
                    bus.dstore <= fr.word[1];
                end
                // Dirty is cleared at this edge, so FLUSH sees the set clean and moves on.
                FWB1: if (!bus.dwait) begin
                    state    <= FLUSH;
                    bus.dWEN <= 1'b0;
                end
`ifdef DCACHE_HITCOUNT_EN
                HCNT: if (!bus.dwait) begin
                    state       <= DONE;
                    bus.dWEN    <= 1'b0;
                    bus.flushed <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_wb.sv
// Directed bench for dcache_wb: a latency-2 memory model logs every completed
// transaction, and each scenario compares against hand-computed values.
module tb_dcache_wb;
    import dcache_wb_pkg::*;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;

    dcache_wb_if bus ();

    dcache_wb dut (.CLK(CLK), .nRST(nRST), .bus(bus));

    always #5 CLK = ~CLK;

    typedef struct {
        logic  w;
        word_t a;
        word_t d;
    } txn_t;

    txn_t  log_q[$];
    word_t mem [0:4095];
    int    n_cmp = 0;
    int    n_bad = 0;

    // 8-cycle hit burst over all sets; only sets 0 and 3 are written.
    logic  b_wr   [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    word_t b_addr [8] = '{32'h104, 32'h08, 32'h10, 32'h18, 32'h20, 32'h28, 32'h30, 32'h38};
    word_t b_data [8] = '{32'h1234, 32'h0, 32'h0, 32'h5555, 32'h0, 32'h0, 32'h0, 32'h0};

    task automatic check(input string tag, input word_t got, input word_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_txn(input string tag, input int i, input logic w, input word_t a, input word_t d);
        if (i < log_q.size()) begin
            check({tag, "_w"}, word_t'(log_q[i].w), word_t'(w));
            check({tag, "_a"}, log_q[i].a, a);
            if (w) check({tag, "_d"}, log_q[i].d, d);
        end else begin
            check({tag, "_missing"}, word_t'(log_q.size()), word_t'(i + 1));
        end
    endtask

    // Memory controller: each request sees dwait high for 2 cycles, low on the 3rd.
    initial begin
        int  lat;
        bit  done;
        for (int i = 0; i < 4096; i++) mem[i] = 32'hA000_0000 | word_t'(i << 2);
        bus.dwait = 1'b1;
        bus.dload = '0;
        lat  = 0;
        done = 1'b0;
        forever begin
            @(negedge CLK);
            done = 1'b0;
            if (nRST && (bus.dREN || bus.dWEN) && !bus.dwait) begin
                log_q.push_back('{bus.dWEN, bus.daddr, bus.dWEN ? bus.dstore : 32'h0});
                if (bus.dWEN) mem[bus.daddr[13:2]] = bus.dstore;
                done = 1'b1;
            end
            @(posedge CLK);
            #1;
            if (done || !(bus.dREN || bus.dWEN)) lat = 0;
            if (bus.dREN || bus.dWEN) begin
                lat++;
                bus.dwait = (lat <= 2);
                bus.dload = bus.dwait ? 32'h0 : mem[bus.daddr[13:2]];
            end else begin
                bus.dwait = 1'b1;
            end
        end
    end

    // One CPU access, started at posedge+1; returns load data and the number of non-hit cycles.
    task automatic access(input logic wr, input word_t a, input word_t d, output word_t rd, output int cyc);
        bus.dmemREN   = ~wr;
        bus.dmemWEN   = wr;
        bus.dmemaddr  = a;
        bus.dmemstore = d;
        cyc = 0;
        rd  = '0;
        forever begin
            @(negedge CLK);
            if (bus.dhit) break;
            cyc++;
            if (cyc > 100) begin
                check("hit_timeout", word_t'(bus.dhit), 32'd1);
                break;
            end
        end
        rd = bus.dmemload;
        @(posedge CLK);
        #1;
        bus.dmemREN = 1'b0;
        bus.dmemWEN = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        word_t rd;
        int    cyc;
        int    base;
        int    n_flush;

        bus.halt      = 1'b0;
        bus.dmemREN   = 1'b0;
        bus.dmemWEN   = 1'b0;
        bus.dmemaddr  = '0;
        bus.dmemstore = '0;

        repeat (2) @(negedge CLK);
        check("rst_dhit",    word_t'(bus.dhit),    32'd0);
        check("rst_dREN",    word_t'(bus.dREN),    32'd0);
        check("rst_dWEN",    word_t'(bus.dWEN),    32'd0);
        check("rst_flushed", word_t'(bus.flushed), 32'd0);
        check("rst_daddr",   bus.daddr,            32'd0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;

        // Cold load: two reads, hit one cycle after the second completes.
        base = log_q.size();
        access(1'b0, 32'h40, 32'h0, rd, cyc);
        check("cold_data", rd, 32'hA000_0040);
        check("cold_cyc",  word_t'(cyc), 32'd7);
        check("cold_ntxn", word_t'(log_q.size() - base), 32'd2);
        check_txn("cold_t0", base,     1'b0, 32'h40, 32'h0);
        check_txn("cold_t1", base + 1, 1'b0, 32'h44, 32'h0);

        // Store hit, then load it back without memory traffic.
        base = log_q.size();
        access(1'b1, 32'h44, 32'hDEAD, rd, cyc);
        check("st_cyc", word_t'(cyc), 32'd0);
        access(1'b0, 32'h44, 32'h0, rd, cyc);
        check("ld_data", rd, 32'hDEAD);
        check("ld_cyc",  word_t'(cyc), 32'd0);
        check("hit_ntxn", word_t'(log_q.size() - base), 32'd0);

        // Conflict miss on a dirty set 0: write-back, then fill.
        base = log_q.size();
        access(1'b0, 32'h100, 32'h0, rd, cyc);
        check("dm_data", rd, 32'hA000_0100);
        check("dm_cyc",  word_t'(cyc), 32'd13);
        check("dm_ntxn", word_t'(log_q.size() - base), 32'd4);
        check_txn("dm_t0", base,     1'b1, 32'h40,  32'hA000_0040);
        check_txn("dm_t1", base + 1, 1'b1, 32'h44,  32'hDEAD);
        check_txn("dm_t2", base + 2, 1'b0, 32'h100, 32'h0);
        check_txn("dm_t3", base + 3, 1'b0, 32'h104, 32'h0);

        // Fill sets 1..7 with clean blocks.
        for (int s = 1; s < 8; s++) begin
            access(1'b0, word_t'(s * 8), 32'h0, rd, cyc);
            check($sformatf("fill%0d_cyc", s),  word_t'(cyc), 32'd7);
            check($sformatf("fill%0d_data", s), rd, 32'hA000_0000 | word_t'(s * 8));
        end

        // Back-to-back hits, one per cycle, across every set.
        base = log_q.size();
        for (int i = 0; i < 8; i++) begin
            bus.dmemREN   = ~b_wr[i];
            bus.dmemWEN   = b_wr[i];
            bus.dmemaddr  = b_addr[i];
            bus.dmemstore = b_data[i];
            @(negedge CLK);
            check($sformatf("burst%0d_dhit", i), word_t'(bus.dhit), 32'd1);
            if (!b_wr[i]) check($sformatf("burst%0d_data", i), bus.dmemload, 32'hA000_0000 | b_addr[i]);
            @(posedge CLK);
            #1;
        end
        bus.dmemREN = 1'b0;
        bus.dmemWEN = 1'b0;
        @(negedge CLK);
        check("burst_ntxn", word_t'(log_q.size() - base), 32'd0);
        @(posedge CLK);
        #1;

        // Halt: only sets 0 and 3 are dirty.
`ifdef DCACHE_HITCOUNT_EN
        n_flush = 5;
`else
        n_flush = 4;
`endif
        base = log_q.size();
        bus.halt = 1'b1;
        cyc = 0;
        do begin
            @(negedge CLK);
            cyc++;
        end while (!bus.flushed && cyc < 400);
        check("flush_done", word_t'(bus.flushed), 32'd1);
        check("flush_ntxn", word_t'(log_q.size() - base), word_t'(n_flush));
        check_txn("fl_t0", base,     1'b1, 32'h100, 32'hA000_0100);
        check_txn("fl_t1", base + 1, 1'b1, 32'h104, 32'h1234);
        check_txn("fl_t2", base + 2, 1'b1, 32'h18,  32'h5555);
        check_txn("fl_t3", base + 3, 1'b1, 32'h1C,  32'hA000_001C);
`ifdef DCACHE_HITCOUNT_EN
        // 19 hit cycles minus 9 misses.
        check_txn("fl_t4", base + 4, 1'b1, 32'h3100, 32'd10);
`endif

        // Flushed is sticky and further requests are ignored.
        @(posedge CLK);
        #1;
        bus.halt     = 1'b0;
        bus.dmemREN  = 1'b1;
        bus.dmemaddr = 32'h08;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check($sformatf("done%0d_flushed", i), word_t'(bus.flushed), 32'd1);
            check($sformatf("done%0d_dhit", i),    word_t'(bus.dhit),    32'd0);
            check($sformatf("done%0d_dREN", i),    word_t'(bus.dREN),    32'd0);
        end
        @(posedge CLK);
        #1;
        bus.dmemREN = 1'b0;
        nRST = 1'b0;
        @(negedge CLK);
        check("rst2_flushed", word_t'(bus.flushed), 32'd0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;

        // Reset cleared the tags: 0x40 misses again. Then dirty it.
        access(1'b0, 32'h40, 32'h0, rd, cyc);
        check("re_cyc", word_t'(cyc), 32'd7);
        access(1'b1, 32'h40, 32'h7777, rd, cyc);
        check("re_st_cyc", word_t'(cyc), 32'd0);

        // Reset while the second write-back word is still waiting.
        bus.dmemREN  = 1'b1;
        bus.dmemaddr = 32'h100;
        cyc = 0;
        do begin
            @(negedge CLK);
            cyc++;
        end while (!(bus.dWEN && bus.daddr == 32'h44) && cyc < 100);
        check("wb1_reach", word_t'(bus.dWEN), 32'd1);
        nRST = 1'b0;
        #1;
        check("wb1_rst_dWEN", word_t'(bus.dWEN), 32'd0);
        check("wb1_rst_dREN", word_t'(bus.dREN), 32'd0);
        @(posedge CLK);
        #1;
        bus.dmemREN = 1'b0;
        nRST = 1'b1;

        // First write-back word reached memory; the line itself was invalidated.
        base = log_q.size();
        access(1'b0, 32'h40, 32'h0, rd, cyc);
        check("post_cyc",  word_t'(cyc), 32'd7);
        check("post_data", rd, 32'h7777);
        check("post_ntxn", word_t'(log_q.size() - base), 32'd2);
        check_txn("post_t0", base, 1'b0, 32'h40, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
